// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests, skid buffer
// for responses that arrive while stalled, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {StFetch, StWait, StFull, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcF_q, pcF_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcPlus4D_q, pcPlus4D_d;
  logic        validD_q, validD_d;

  logic        blocked;
  logic        redirect;
  logic        retire;
  logic [31:0] retireInstr;
  logic [31:0] pcPlus4F;

  assign blocked  = StallF | StallD;
  assign redirect = PCSrcD & ~StallD;
  assign pcPlus4F = pcF_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pcF_q      <= RESET_PC;
      skid_q     <= 32'h0;
      instrD_q   <= 32'h0;
      pcPlus4D_q <= 32'h0;
      validD_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcF_q      <= pcF_d;
      skid_q     <= skid_d;
      instrD_q   <= instrD_d;
      pcPlus4D_q <= pcPlus4D_d;
      validD_q   <= validD_d;
    end
  end

  // Redirect always outranks retirement: the word in flight or buffered is wrong-path.
  always_comb begin
    state_d     = state_q;
    pcF_d       = pcF_q;
    skid_d      = skid_q;
    retire      = 1'b0;
    retireInstr = skid_q;
    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          pcF_d   = PCBranchD;
          state_d = StDiscard;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          pcF_d   = PCBranchD;
          state_d = ImemReady ? StFetch : StDiscard;
        end else if (ImemReady) begin
          if (!blocked) begin
            retire      = 1'b1;
            retireInstr = ImemRdata;
            state_d     = StFetch;
          end else begin
            skid_d  = ImemRdata;
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (redirect) begin
          pcF_d   = PCBranchD;
          state_d = StFetch;
        end else if (!blocked) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StDiscard: begin
        if (redirect) pcF_d = PCBranchD;
        // Leaving on the stale response avoids waiting for one that will never come.
        if (ImemReady) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (retire) pcF_d = pcPlus4F;
  end

  always_comb begin
    ImemReq  = rst_n && (state_q == StFetch);
    ImemAddr = pcF_q;
    if (StallD) begin
      instrD_d   = instrD_q;
      pcPlus4D_d = pcPlus4D_q;
      validD_d   = validD_q;
    end else if (retire) begin
      instrD_d   = retireInstr;
      pcPlus4D_d = pcPlus4F;
      validD_d   = 1'b1;
    end else begin
      instrD_d   = 32'h0;
      pcPlus4D_d = 32'h0;
      validD_d   = 1'b0;
    end
  end

  assign InstrD   = instrD_q;
  assign PCPlus4D = pcPlus4D_q;
  assign ValidD   = validD_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected requests/retirements,
// a monitor pops and compares them as the DUT presents them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0;
  logic [31:0] PCBranchD = 32'h0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic [31:0] ImemRdata;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemReady (ImemReady),
    .ImemRdata (ImemRdata),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int cyc;} req_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc4; int cyc;} ret_t;

  req_t reqQ[$];
  ret_t retQ[$];

  int errors = 0;
  int checks = 0;
  int sc = 0;

  // memory model state
  int          lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pendAddr = 32'h0;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expReq(input logic [31:0] a, input int c);
    req_t e;
    e.addr = a;
    e.cyc  = c;
    reqQ.push_back(e);
  endtask

  task automatic expRet(input logic [31:0] a, input logic [31:0] pc4, input int c);
    ret_t e;
    e.instr = instrOf(a);
    e.pc4   = pc4;
    e.cyc   = c;
    retQ.push_back(e);
  endtask

  task automatic goTo(input int k);
    while (sc < k) begin
      @(negedge clk);
      sc++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'h0;
    pend = 1'b0;
    lat = 1;
    #1;
    check("rst_req", 32'(ImemReq), 32'h0);
    check("rst_instr", InstrD, 32'h0);
    check("rst_pc4", PCPlus4D, 32'h0);
    check("rst_valid", 32'(ValidD), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sc = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (retQ.size() != 0 && n < 60) begin
      @(negedge clk);
      sc++;
      n++;
    end
    check({name, "_ret_left"}, retQ.size(), 32'h0);
    check({name, "_req_left"}, reqQ.size(), 32'h0);
    retQ.delete();
    reqQ.delete();
  endtask

  // Variable-latency memory: response exactly lat cycles after the request cycle.
  initial begin
    ImemReady = 1'b0;
    ImemRdata = 32'hBAD0_0000;
    forever begin
      @(negedge clk);
      #1;
      ImemReady = 1'b0;
      ImemRdata = 32'hBAD0_0000;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ImemReady = 1'b1;
          ImemRdata = instrOf(pendAddr);
          pend = 1'b0;
        end
      end
      if (ImemReq) begin
        pend = 1'b1;
        cnt = lat;
        pendAddr = ImemAddr;
      end
    end
  end

  // Monitor: cycle 0 is the first sampled cycle with rst_n high.
  initial begin
    req_t er;
    ret_t et;
    int   mcyc;
    bit   prevStallD;
    mcyc = 0;
    prevStallD = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mcyc = 0;
        prevStallD = 1'b0;
      end else begin
        if (ImemReq && reqQ.size() > 0) begin
          er = reqQ.pop_front();
          check("req_addr", ImemAddr, er.addr);
          if (er.cyc >= 0) check("req_cycle", mcyc, er.cyc);
        end
        if (ValidD && !prevStallD) begin
          if (retQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire: got instr %h pc4 %h at cycle %0d, required none",
                     InstrD, PCPlus4D, mcyc);
          end else begin
            et = retQ.pop_front();
            check("ret_instr", InstrD, et.instr);
            check("ret_pc4", PCPlus4D, et.pc4);
            if (et.cyc >= 0) check("ret_cycle", mcyc, et.cyc);
          end
        end
        prevStallD = StallD;
        mcyc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line fetch, latency 1
    doReset();
    expReq(32'h0040_0000, 0); expReq(32'h0040_0004, 2); expReq(32'h0040_0008, 4);
    expRet(32'h0040_0000, 32'h0040_0004, 2);
    expRet(32'h0040_0004, 32'h0040_0008, 4);
    expRet(32'h0040_0008, 32'h0040_000C, 6);
    goTo(3); check("p1_bubble3", 32'(ValidD), 32'h0);
    goTo(5); check("p1_bubble5", 32'(ValidD), 32'h0);
    drain("p1");

    // Latency 3, stall on response arrival -> skid buffer
    doReset(); lat = 3;
    expReq(32'h0040_0000, 0); expReq(32'h0040_0004, 4); expReq(32'h0040_0008, 12);
    expRet(32'h0040_0000, 32'h0040_0004, 4);
    expRet(32'h0040_0004, 32'h0040_0008, 12);
    expRet(32'h0040_0008, 32'h0040_000C, 16);
    goTo(4); StallD = 1'b1;
    goTo(7); StallF = 1'b1;
    for (int k = 8; k <= 10; k++) begin
      goTo(k);
      check("p2_full_noreq", 32'(ImemReq), 32'h0);
      check("p2_hold_instr", InstrD, instrOf(32'h0040_0000));
      check("p2_hold_valid", 32'(ValidD), 32'h1);
    end
    goTo(11); StallF = 1'b0; StallD = 1'b0;
    drain("p2");

    // Redirect in WAIT, stale response two cycles away
    doReset(); lat = 3;
    expReq(32'h0040_0000, 0); expReq(32'h0000_0100, 4);
    expRet(32'h0000_0100, 32'h0000_0104, 8);
    goTo(1); PCSrcD = 1'b1; PCBranchD = 32'h0000_0100;
    goTo(2); PCSrcD = 1'b0;
    check("p3_discard_noreq2", 32'(ImemReq), 32'h0);
    check("p3_bubble", 32'(ValidD), 32'h0);
    goTo(3); check("p3_discard_noreq3", 32'(ImemReq), 32'h0);
    drain("p3");

    // Redirect coincident with ImemReady
    doReset(); lat = 1;
    expReq(32'h0040_0000, 0); expReq(32'h0000_0200, 2);
    expRet(32'h0000_0200, 32'h0000_0204, 4);
    goTo(1); PCSrcD = 1'b1; PCBranchD = 32'h0000_0200;
    goTo(2); PCSrcD = 1'b0;
    check("p4_req", 32'(ImemReq), 32'h1);
    check("p4_addr", ImemAddr, 32'h0000_0200);
    check("p4_bubble", 32'(ValidD), 32'h0);
    drain("p4");

    // PCSrcD ignored while StallD
    doReset(); lat = 1;
    expReq(32'h0040_0000, 0); expReq(32'h0040_0004, 2); expReq(32'h0040_0008, 5);
    expRet(32'h0040_0000, 32'h0040_0004, 2);
    expRet(32'h0040_0004, 32'h0040_0008, 5);
    expRet(32'h0040_0008, 32'h0040_000C, 7);
    goTo(2); StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h0000_0300;
    goTo(4);
    check("p5_noreq", 32'(ImemReq), 32'h0);
    check("p5_hold_instr", InstrD, instrOf(32'h0040_0000));
    check("p5_hold_pc4", PCPlus4D, 32'h0040_0004);
    check("p5_hold_valid", 32'(ValidD), 32'h1);
    StallD = 1'b0; PCSrcD = 1'b0;
    drain("p5");

    // Async reset during WAIT; stale response lands in FETCH and is ignored
    doReset(); lat = 1;
    expReq(32'h0040_0000, 0); expReq(32'h0040_0004, 2);
    expRet(32'h0040_0000, 32'h0040_0004, 2);
    goTo(2); lat = 3; StallD = 1'b1;
    goTo(3); rst_n = 1'b0;
    #1;
    check("p6_rst_req", 32'(ImemReq), 32'h0);
    check("p6_rst_instr", InstrD, 32'h0);
    check("p6_rst_pc4", PCPlus4D, 32'h0);
    check("p6_rst_valid", 32'(ValidD), 32'h0);
    @(negedge clk); StallD = 1'b0;
    @(negedge clk); rst_n = 1'b1; sc = 0;
    expReq(32'h0040_0000, 0);
    expRet(32'h0040_0000, 32'h0040_0004, 4);
    drain("p6");

    // PC wrap at 0xFFFF_FFFC
    doReset(); lat = 1;
    expReq(32'h0040_0000, 0); expReq(32'hFFFF_FFFC, 2); expReq(32'h0000_0000, 4);
    expRet(32'hFFFF_FFFC, 32'h0000_0000, 4);
    expRet(32'h0000_0000, 32'h0000_0004, 6);
    goTo(1); PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
    goTo(2); PCSrcD = 1'b0;
    drain("p7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
